count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor_if.sv | 25 ++
 rtl/count_monitor.sv | 110 +++++++++++
 tb/tb_count_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/count_monitor_if.sv
// Bundles the upstream counter observation inputs and the monitor's fault-record outputs.
interface count_monitor_if #(
    parameter int ERR_W  = 4,
    parameter int WRAP_W = 8
);
    logic              en;
    logic [2:0]        count;
    logic              clr_err;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;
    logic [2:0]        fault_obs;
    logic [2:0]        fault_exp;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [1:0]        state;

    modport master (
        output en, count, clr_err,
        input  err_flag, err_cnt, fault_obs, fault_exp, wrap_cnt, state
    );

    modport slave (
        input  en, count, clr_err,
        output err_flag, err_cnt, fault_obs, fault_exp, wrap_cnt, state
    );
endinterface

// File: rtl/count_monitor.sv
// Watches a 3-bit up-counter and checks that each registered count follows from the previous
// count and enable; records the first fault, counts mismatches and counts legal 7->0 wraps.
module count_monitor #(
    parameter int ERR_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic clk,
    input  logic rst,
    count_monitor_if.slave mon
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] TRACK = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              en_q;
    logic [2:0]        count_q;
    logic              errFlag_q, errFlag_d;
    logic [ERR_W-1:0]  errCnt_q, errCnt_d;
    logic [2:0]        faultObs_q, faultObs_d;
    logic [2:0]        faultExp_q, faultExp_d;
    logic [WRAP_W-1:0] wrapCnt_q, wrapCnt_d;

    logic [2:0] expVal;
    logic       isIdle;
    logic       mismatch;
    logic       wrapSeen;

    // In IDLE the counter has just left reset, so the only legal value is 0.
    always_comb begin
        isIdle   = (state_q == IDLE);
        expVal   = isIdle ? 3'd0 : (count_q + {2'b00, en_q});
        mismatch = (mon.count != expVal);
        wrapSeen = !isIdle && (count_q == 3'd7) && en_q && (mon.count == 3'd0) && !mismatch;
    end

    always_comb begin
        state_d    = state_q;
        errFlag_d  = errFlag_q;
        errCnt_d   = errCnt_q;
        faultObs_d = faultObs_q;
        faultExp_d = faultExp_q;
        wrapCnt_d  = wrapSeen ? wrapCnt_q + 1'b1 : wrapCnt_q;

        case (state_q)
            IDLE, TRACK: begin
                state_d = TRACK;
                if (mismatch) begin
                    state_d    = FAULT;
                    errFlag_d  = 1'b1;
                    errCnt_d   = {{(ERR_W-1){1'b0}}, 1'b1};
                    faultObs_d = mon.count;
                    faultExp_d = expVal;
                end
            end
            FAULT: begin
                // A clear coinciding with a mismatch restarts the record on the new fault.
                if (mismatch && mon.clr_err) begin
                    errCnt_d   = {{(ERR_W-1){1'b0}}, 1'b1};
                    faultObs_d = mon.count;
                    faultExp_d = expVal;
                end else if (mismatch) begin
                    if (errCnt_q != {ERR_W{1'b1}}) begin
                        errCnt_d = errCnt_q + 1'b1;
                    end
                end else if (mon.clr_err) begin
                    state_d    = TRACK;
                    errFlag_d  = 1'b0;
                    errCnt_d   = '0;
                    faultObs_d = '0;
                    faultExp_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            count_q    <= '0;
            errFlag_q  <= 1'b0;
            errCnt_q   <= '0;
            faultObs_q <= '0;
            faultExp_q <= '0;
            wrapCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= mon.en;
            count_q    <= mon.count;
            errFlag_q  <= errFlag_d;
            errCnt_q   <= errCnt_d;
            faultObs_q <= faultObs_d;
            faultExp_q <= faultExp_d;
            wrapCnt_q  <= wrapCnt_d;
        end
    end

    assign mon.state     = state_q;
    assign mon.err_flag  = errFlag_q;
    assign mon.err_cnt   = errCnt_q;
    assign mon.fault_obs = faultObs_q;
    assign mon.fault_exp = faultExp_q;
    assign mon.wrap_cnt  = wrapCnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a sequence-rule model is checked every cycle,
// and literal expectations pin the model at the interesting points.
module tb_count_monitor;

    localparam int ERR_W  = 4;
    localparam int WRAP_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic clk;
    logic rst;

    count_monitor_if #(.ERR_W(ERR_W), .WRAP_W(WRAP_W)) mon ();

    count_monitor #(.ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    int assertCount = 0;
    int failCount   = 0;
    bit checkOn     = 0;

    // Model of the rules: counter history plus the fault record, held as plain integers.
    bit mStarted = 0;
    int mPrevC   = 0;
    int mPrevE   = 0;
    bit mFaulty  = 0;
    int mErrs    = 0;
    int mObs     = 0;
    int mExp     = 0;
    int mWraps   = 0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it and report a FAIL line if the values differ.
    task automatic checkOutput(input string name, input int act, input int req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model by one clock edge with the inputs the DUT sampled.
    task automatic modelStep(input bit r, input bit e, input int c, input bit clr);
        int expected;
        bit bad;
        if (r) begin
            mStarted = 0; mPrevC = 0; mPrevE = 0; mFaulty = 0;
            mErrs = 0; mObs = 0; mExp = 0; mWraps = 0;
        end else begin
            expected = mStarted ? (mPrevC + mPrevE) % 8 : 0;
            bad = (c != expected);
            if (bad) begin
                if (!mFaulty || clr) begin
                    mErrs = 1; mObs = c; mExp = expected;
                end else begin
                    mErrs = (mErrs + 1 > ERR_MAX) ? ERR_MAX : mErrs + 1;
                end
                mFaulty = 1;
            end else if (clr && mFaulty) begin
                mFaulty = 0; mErrs = 0; mObs = 0; mExp = 0;
            end
            if (mStarted && !bad && mPrevC == 7 && mPrevE == 1 && c == 0)
                mWraps = (mWraps + 1) % (1 << WRAP_W);
            mPrevC = c;
            mPrevE = e;
            mStarted = 1;
        end
    endtask

    // Drive one cycle of inputs from a negedge, update the model at the edge, return at the next negedge.
    task automatic applyStimulus(input bit r, input bit e, input int c, input bit clr);
        rst         = r;
        mon.en      = e;
        mon.count   = 3'(c);
        mon.clr_err = clr;
        @(posedge clk);
        modelStep(r, e, c, clr);
        @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model_state", int'(mon.state), !mStarted ? 0 : (mFaulty ? 2 : 1));
            checkOutput("model_err_flag", int'(mon.err_flag), int'(mFaulty));
            checkOutput("model_err_cnt", int'(mon.err_cnt), mErrs);
            checkOutput("model_fault_obs", int'(mon.fault_obs), mObs);
            checkOutput("model_fault_exp", int'(mon.fault_exp), mExp);
            checkOutput("model_wrap_cnt", int'(mon.wrap_cnt), mWraps);
        end
    end

    initial begin
        int v;
        rst = 1'b1;
        mon.en = 1'b0;
        mon.count = 3'd0;
        mon.clr_err = 1'b0;
        @(negedge clk);

        // Reset state.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOn = 1;
        checkOutput("reset_state", int'(mon.state), 0);
        checkOutput("reset_err_cnt", int'(mon.err_cnt), 0);
        checkOutput("reset_wrap_cnt", int'(mon.wrap_cnt), 0);

        // Twenty clean increments: wraps observed at the 8th and 16th increments.
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, i % 8, 0);
        checkOutput("clean_err_flag", int'(mon.err_flag), 0);
        checkOutput("clean_wrap_cnt", int'(mon.wrap_cnt), 2);
        checkOutput("clean_state", int'(mon.state), 1);

        // Continue 4..7,0..3 (third wrap), then force 5 where 4 is expected.
        for (int i = 4; i < 12; i++) applyStimulus(0, 1, i % 8, 0);
        applyStimulus(0, 1, 5, 0);
        checkOutput("first_fault_flag", int'(mon.err_flag), 1);
        checkOutput("first_fault_cnt", int'(mon.err_cnt), 1);
        checkOutput("first_fault_obs", int'(mon.fault_obs), 5);
        checkOutput("first_fault_exp", int'(mon.fault_exp), 4);
        checkOutput("first_fault_state", int'(mon.state), 2);
        checkOutput("first_fault_wrap", int'(mon.wrap_cnt), 3);

        // Twenty further mismatches (each step +3 instead of +1) saturate the counter.
        v = 5;
        for (int i = 0; i < 20; i++) begin
            v = (v + 3) % 8;
            applyStimulus(0, 1, v, 0);
        end
        checkOutput("sat_err_cnt", int'(mon.err_cnt), 15);
        checkOutput("sat_fault_obs", int'(mon.fault_obs), 5);
        checkOutput("sat_fault_exp", int'(mon.fault_exp), 4);

        // v is now 1: clean clear with 2, then clear plus mismatch from TRACK.
        applyStimulus(0, 1, 2, 1);
        checkOutput("clr_clean_flag", int'(mon.err_flag), 0);
        checkOutput("clr_clean_cnt", int'(mon.err_cnt), 0);
        checkOutput("clr_clean_state", int'(mon.state), 1);
        applyStimulus(0, 1, 6, 1);
        checkOutput("clr_mis_cnt", int'(mon.err_cnt), 1);
        checkOutput("clr_mis_state", int'(mon.state), 2);
        checkOutput("clr_mis_exp", int'(mon.fault_exp), 3);

        // In FAULT: one more mismatch, then clear plus mismatch recaptures the record.
        applyStimulus(0, 1, 0, 0);
        checkOutput("fault_second_cnt", int'(mon.err_cnt), 2);
        applyStimulus(0, 0, 4, 1);
        checkOutput("recap_cnt", int'(mon.err_cnt), 1);
        checkOutput("recap_obs", int'(mon.fault_obs), 4);
        checkOutput("recap_exp", int'(mon.fault_exp), 1);

        // Clean clear, climb to 2 through a wrap, then hold en low while count changes 2->3.
        applyStimulus(0, 1, 4, 1);
        applyStimulus(0, 1, 5, 0);
        applyStimulus(0, 1, 6, 0);
        applyStimulus(0, 1, 7, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 2, 0);
        applyStimulus(0, 0, 3, 0);
        checkOutput("hold_fault_exp", int'(mon.fault_exp), 2);
        checkOutput("hold_fault_obs", int'(mon.fault_obs), 3);
        checkOutput("hold_wrap_cnt", int'(mon.wrap_cnt), 4);

        // Reset in FAULT wins over a simultaneous clear and mismatch.
        applyStimulus(1, 1, 5, 1);
        checkOutput("rst_state", int'(mon.state), 0);
        checkOutput("rst_flag", int'(mon.err_flag), 0);
        checkOutput("rst_wrap", int'(mon.wrap_cnt), 0);
        checkOutput("rst_obs", int'(mon.fault_obs), 0);

        // First post-reset cycle shows 1 instead of 0.
        applyStimulus(0, 1, 1, 0);
        checkOutput("post_rst_flag", int'(mon.err_flag), 1);
        checkOutput("post_rst_exp", int'(mon.fault_exp), 0);
        checkOutput("post_rst_obs", int'(mon.fault_obs), 1);

        // Wraps still count while in FAULT.
        for (int i = 2; i < 9; i++) applyStimulus(0, 1, i % 8, 0);
        checkOutput("fault_wrap_cnt", int'(mon.wrap_cnt), 1);
        checkOutput("fault_wrap_state", int'(mon.state), 2);

        applyStimulus(0, 1, 1, 0);
        checkOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
